// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : MIPS IF stage, one outstanding imem read, one-entry output buffer
// Revision   : 1.0
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] next_PC,
    output logic        fetch_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic [31:0] target;
    logic        redirect;
    logic        slot_free;
    logic        accept;
    logic        buf_write;

    assign redirect  = JumpD | PCSrcD;
    assign target    = JumpD ? PCJumpD : PCBranchD;
    assign slot_free = !fetch_valid | !StallF;
    assign imem_addr = pc_q & 32'hFFFF_FFFC;
    assign accept    = imem_req & imem_gnt;

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        buf_write = 1'b0;
        case (state)
            IDLE: begin
                // Reset gating keeps the request low while the async reset is held.
                imem_req = slot_free & !redirect & !reset;
                if (imem_req && imem_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    buf_write = !redirect;
                    state_nxt = IDLE;
                end else if (redirect) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            pc_q   <= RESET_PC;
            addr_q <= 32'd0;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                pc_q <= target & 32'hFFFF_FFFC;
            end else if (accept) begin
                pc_q <= pc_q + 32'd4;
            end
            if (accept) begin
                addr_q <= imem_addr;
            end
        end
    end

    // Redirect flush beats a same-cycle response; a response beats consumption.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instruction <= 32'd0;
            next_PC     <= 32'd0;
            fetch_valid <= 1'b0;
        end else if (redirect) begin
            instruction <= 32'd0;
            next_PC     <= 32'd0;
            fetch_valid <= 1'b0;
        end else if (buf_write) begin
            instruction <= imem_rdata;
            next_PC     <= addr_q + 32'd4;
            fetch_valid <= 1'b1;
        end else if (fetch_valid && !StallF) begin
            instruction <= 32'd0;
            next_PC     <= 32'd0;
            fetch_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of the IF/ID register. It owns the PC, issues word reads to a variable-latency instruction memory (one outstanding request), and presents each fetched instruction with its PC+4 in a one-entry output buffer. It applies branch/jump redirects from the decode stage, squashing any in-flight or buffered wrong-path fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- StallF  in  1  hazard-unit stall; buffered instruction not consumed this cycle
- PCSrcD  in  1  taken branch resolved in decode
- PCBranchD  in  32  branch target
- JumpD  in  1  jump in decode; priority over PCSrcD
- PCJumpD  in  32  jump target
- imem_req  out  1  read request valid
- imem_addr  out  32  request word address, bits[1:0] driven 0
- imem_gnt  in  1  request accepted when imem_req && imem_gnt at posedge
- imem_rvalid  in  1  read data valid; at least 1 cycle after accept
- imem_rdata  in  32  instruction word
- instruction  out  32  buffered instruction to IF/ID
- next_PC  out  32  fetch address + 4 of the buffered instruction
- fetch_valid  out  1  buffer holds a valid instruction; hazard unit drives IF/ID clr when 0

## Operation
- State: pc_q (next fetch address), addr_q (address of outstanding request), FSM, output buffer (instruction, next_PC, fetch_valid).
- redirect = JumpD | PCSrcD; target = JumpD ? PCJumpD : PCBranchD.
- slot_free = !fetch_valid | !StallF.
- FSM states:
  - IDLE: no request outstanding.
    - imem_req = slot_free & !redirect; imem_addr = {pc_q[31:2],2'b00}.
    - On accept: addr_q <= imem_addr; pc_q <= pc_q + 4; go to WAIT.
  - WAIT: request outstanding, on the correct path. imem_req = 0.
    - rvalid & !redirect: write buffer (instruction <= imem_rdata, next_PC <= addr_q + 4, fetch_valid <= 1); go to IDLE.
    - rvalid & redirect: discard the data; go to IDLE.
    - !rvalid & redirect: go to DROP.
  - DROP: outstanding response is wrong-path. imem_req = 0. On rvalid: discard; go to IDLE.
- Buffer consume: at a posedge with fetch_valid & !StallF, clear instruction, next_PC and fetch_valid to 0, unless written in the same cycle (write wins).
- Buffer space is guaranteed when a response arrives. A request is issued only when slot_free, and only responses write the buffer.
- Redirect, at any posedge regardless of StallF:
  - pc_q <= {target[31:2],2'b00}.
  - Buffer cleared to 0 / fetch_valid 0; this overrides a same-cycle response write.
  - FSM transitions as above.
- Arithmetic: all +4 are modulo 2^32, so 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset values: pc_q = RESET_PC, FSM = IDLE, instruction = 0, next_PC = 0, fetch_valid = 0, imem_req = 0 while reset is high.
- First imem_req is in the first cycle after reset deasserts.
- Latency: with gnt in the request cycle and rvalid N cycles after accept, fetch_valid rises N cycles after accept.
- Peak throughput: 1 instruction per 2 cycles (N = 1).
- imem_req/imem_addr need not be held. The memory is side-effect free, so a dropped request has no effect.
- Redirect effect: the next request, in the cycle after the redirect, is to the target (IDLE case). In WAIT/DROP, it follows the drain of the outstanding response.
- Reset mid-transaction: FSM returns to IDLE. The instruction memory shares this reset and discards its in-flight response.

## Test plan
- Reset release, RESET_PC=0, gnt=1, rvalid 1 cycle after accept, StallF=0 -> addresses 0,4,8 issued on alternate cycles; instruction = mem words with next_PC = 4,8,12.
- StallF held 5 cycles with fetch_valid=1 -> instruction/next_PC unchanged, imem_req=0 after the buffered fetch; resume yields the next sequential word with no skip or duplicate.
- PCSrcD=1, PCBranchD=0x40 while in WAIT, rvalid 3 cycles later -> fetch_valid=0, response discarded, next imem_addr=0x40, next_PC=0x44.
- JumpD=1 (PCJumpD=0x100) and PCSrcD=1 (PCBranchD=0x80) in the same cycle as rvalid -> data discarded, next imem_addr=0x100.
- RESET_PC=0xFFFF_FFFC -> first next_PC=0, second imem_addr=0.
- Reset asserted in WAIT between cycles -> outputs 0 immediately; first request after release is to RESET_PC.
